// File: rtl/div_request_stage.sv
// Issue stage ahead of the combinational 16/8 divider: buffers requests, waits a
// settle interval, then captures the divider result (or a local /0 trap) into a
// valid/ready output register.
module div_request_stage #(
   parameter int DEPTH         = 4,
   parameter int TAG_W         = 4,
   parameter int SETTLE_CYCLES = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [15:0]      in_dividend,
   input  logic [7:0]       in_divisor,
   input  logic [TAG_W-1:0] in_tag,
   output logic [15:0]      div_dividend,
   output logic [7:0]       div_divisor,
   input  logic [7:0]       div_quotient,
   input  logic [7:0]       div_remainder,
   input  logic             div_done,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [7:0]       out_quotient,
   output logic [7:0]       out_remainder,
   output logic [TAG_W-1:0] out_tag,
   output logic [1:0]       out_status
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [PTR_W:0]   FULL     = (PTR_W + 1)'(DEPTH);
   localparam logic [PTR_W:0]   ONE      = (PTR_W + 1)'(1);

   typedef struct packed {
      logic [15:0]      dividend;
      logic [7:0]       divisor;
      logic [TAG_W-1:0] tag;
   } req_t;

   typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE} state_t;

   req_t             mem [DEPTH];
   req_t             head;
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [PTR_W:0]   count;
   logic             push, pop;
   logic [15:0]      last_dividend;
   logic [7:0]       last_divisor;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             capture, can_cap, head_zero;

   assign head      = mem[rd_ptr];
   assign in_ready  = (count != FULL);
   assign push      = in_valid && in_ready;
   assign pop       = capture;
   assign head_zero = (head.divisor == 8'h00);
   assign can_cap   = !out_valid || out_ready;

   // Operands follow the head entry; when empty they hold what was last presented.
   assign div_dividend = (count != '0) ? head.dividend : last_dividend;
   assign div_divisor  = (count != '0) ? head.divisor  : last_divisor;

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= '{dividend: in_dividend, divisor: in_divisor, tag: in_tag};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         count         <= '0;
         last_dividend <= '0;
         last_divisor  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (count != '0) begin
            last_dividend <= head.dividend;
            last_divisor  <= head.divisor;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      capture   = 1'b0;
      case (state)
         IDLE: begin
            if (count != '0) begin
               cnt_nxt   = CNT_LOAD;
               state_nxt = SETTLE;
            end
         end
         SETTLE: begin
            if (cnt == '0) state_nxt = CAPTURE;
            else           cnt_nxt   = cnt - 1'b1;
         end
         CAPTURE: begin
            // A zero divisor never waits on div_done: its result is trapped here.
            if (can_cap && (head_zero || div_done)) begin
               capture = 1'b1;
               if (count > ONE) begin
                  cnt_nxt   = CNT_LOAD;
                  state_nxt = SETTLE;
               end else begin
                  state_nxt = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid     <= 1'b0;
         out_quotient  <= '0;
         out_remainder <= '0;
         out_tag       <= '0;
         out_status    <= 2'b00;
      end else if (capture) begin
         out_valid     <= 1'b1;
         out_tag       <= head.tag;
         out_quotient  <= head_zero ? 8'hFF : div_quotient;
         out_remainder <= head_zero ? 8'h00 : div_remainder;
         out_status    <= head_zero ? 2'b01 : 2'b00;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end
endmodule

// File: tb/tb_div_request_stage.sv
// Bench for div_request_stage: stub divider, scoreboard of expected results
// checked on every output handshake, plus per-scenario timing checks.
module tb_div_request_stage;
   typedef struct packed {
      logic [7:0] q;
      logic [7:0] r;
      logic [3:0] tag;
      logic [1:0] st;
   } exp_t;

   logic        clk, rst;
   logic        in_valid, in_ready;
   logic [15:0] in_dividend;
   logic [7:0]  in_divisor;
   logic [3:0]  in_tag;
   logic [15:0] div_dividend;
   logic [7:0]  div_divisor;
   logic [7:0]  div_quotient, div_remainder;
   logic        div_done;
   logic        out_valid, out_ready;
   logic [7:0]  out_quotient, out_remainder;
   logic [3:0]  out_tag;
   logic [1:0]  out_status;

   int     checks = 0;
   int     errors = 0;
   exp_t   exp_q[$];
   time    hs_times[$];
   bit     rec_en = 0;
   bit     stub_fixed = 0;

   div_request_stage #(.DEPTH(4), .TAG_W(4), .SETTLE_CYCLES(1)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_dividend(in_dividend), .in_divisor(in_divisor), .in_tag(in_tag),
      .div_dividend(div_dividend), .div_divisor(div_divisor),
      .div_quotient(div_quotient), .div_remainder(div_remainder), .div_done(div_done),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_quotient(out_quotient), .out_remainder(out_remainder),
      .out_tag(out_tag), .out_status(out_status)
   );

   initial clk = 0;
   always #5 clk = ~clk;

   // Stub divider: fixed answer or a real (truncated) divide; garbage on /0.
   always_comb begin
      if (stub_fixed) begin
         div_quotient  = 8'h2A;
         div_remainder = 8'h05;
      end else if (div_divisor != 0) begin
         div_quotient  = 8'(div_dividend / {8'h00, div_divisor});
         div_remainder = 8'(div_dividend % {8'h00, div_divisor});
      end else begin
         div_quotient  = 8'hEE;
         div_remainder = 8'hEE;
      end
   end

   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         exp_t got, e;
         got = '{q: out_quotient, r: out_remainder, tag: out_tag, st: out_status};
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_unexpected: got q=%h r=%h tag=%0d st=%b, nothing expected",
                     got.q, got.r, got.tag, got.st);
         end else begin
            e = exp_q.pop_front();
            if (got !== e) begin
               errors++;
               $display("FAIL scoreboard_result: got q=%h r=%h tag=%0d st=%b, expected q=%h r=%h tag=%0d st=%b",
                        got.q, got.r, got.tag, got.st, e.q, e.r, e.tag, e.st);
            end
         end
         if (rec_en) hs_times.push_back($time);
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic push(input logic [15:0] dd, input logic [7:0] dv, input logic [3:0] tg);
      exp_t e;
      bit   acc = 0;
      if (dv == 0)         e = '{q: 8'hFF, r: 8'h00, tag: tg, st: 2'b01};
      else if (stub_fixed) e = '{q: 8'h2A, r: 8'h05, tag: tg, st: 2'b00};
      else e = '{q: 8'(dd / {8'h00, dv}), r: 8'(dd % {8'h00, dv}), tag: tg, st: 2'b00};
      in_valid = 1; in_dividend = dd; in_divisor = dv; in_tag = tg;
      for (int i = 0; i < 40 && !acc; i++) begin
         @(negedge clk);
         acc = in_ready;
         if (acc) exp_q.push_back(e);
         @(posedge clk); #1;
      end
      in_valid = 0;
      checks++;
      if (!acc) begin
         errors++;
         $display("FAIL push_timeout: tag %0d not accepted, in_ready=%b required 1", tg, in_ready);
      end
   endtask

   task automatic wait_drain(input int bound);
      for (int i = 0; i < bound && exp_q.size() != 0; i++) tick();
      tick(2);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d results outstanding, required 0", exp_q.size());
      end
   endtask

   task automatic test_reset;
      rst = 1; in_valid = 0; in_dividend = 0; in_divisor = 0; in_tag = 0;
      out_ready = 0; div_done = 0;
      #1;
      checks++;
      if ({in_ready, out_valid, out_quotient, out_remainder, out_tag, out_status} !== {1'b1, 1'b0, 22'd0}) begin
         errors++;
         $display("FAIL reset_outputs: in_ready=%b out_valid=%b q=%h r=%h tag=%0d st=%b, required 1 0 0 0 0 00",
                  in_ready, out_valid, out_quotient, out_remainder, out_tag, out_status);
      end
      checks++;
      if ({div_dividend, div_divisor} !== 24'd0) begin
         errors++;
         $display("FAIL reset_operands: div=%h/%h required 0000/00", div_dividend, div_divisor);
      end
      tick(2);
      rst = 0;
      tick();
   endtask

   task automatic test_reset_mid_op;
      out_ready = 1; div_done = 1; stub_fixed = 0;
      push(16'd500, 8'd3, 4'd1);
      push(16'd600, 8'd4, 4'd2);
      // FSM is now settling on tag 1; the third request is cut by reset.
      in_valid = 1; in_dividend = 16'd700; in_divisor = 8'd5; in_tag = 4'd4;
      #2 rst = 1; in_valid = 0;
      exp_q.delete();
      #1;
      checks++;
      if ({out_valid, in_ready, div_dividend, div_divisor} !== {1'b0, 1'b1, 24'd0}) begin
         errors++;
         $display("FAIL reset_mid_op: out_valid=%b in_ready=%b div=%h/%h, required 0 1 0000/00",
                  out_valid, in_ready, div_dividend, div_divisor);
      end
      tick();
      rst = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++;
         if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_fifo_empty: out_valid=%b cycle %0d, required 0", out_valid, i);
         end
      end
      push(16'd900, 8'd9, 4'd9);
      wait_drain(20);
   endtask

   task automatic test_single;
      out_ready = 1; div_done = 1; stub_fixed = 1;
      push(16'h1234, 8'h07, 4'd3);
      checks++;
      if ({div_dividend, div_divisor} !== {16'h1234, 8'h07}) begin
         errors++;
         $display("FAIL single_operands: div=%h/%h required 1234/07", div_dividend, div_divisor);
      end
      for (int i = 1; i <= 3; i++) begin
         tick();
         checks++;
         if (out_valid !== (i == 3)) begin
            errors++;
            $display("FAIL single_latency: out_valid=%b at E+%0d, required %b", out_valid, i, i == 3);
         end
      end
      checks++;
      if ({out_quotient, out_remainder, out_tag, out_status} !== {8'h2A, 8'h05, 4'd3, 2'b00}) begin
         errors++;
         $display("FAIL single_result: q=%h r=%h tag=%0d st=%b, required 2a 05 3 00",
                  out_quotient, out_remainder, out_tag, out_status);
      end
      wait_drain(10);
      stub_fixed = 0;
   endtask

   task automatic test_div_zero;
      bit seen = 0;
      out_ready = 1; div_done = 0;
      push(16'd1000, 8'd0, 4'd5);
      for (int i = 0; i < 10 && !seen; i++) begin
         tick();
         seen = out_valid;
      end
      checks++;
      if (!seen || {out_quotient, out_remainder, out_tag, out_status} !== {8'hFF, 8'h00, 4'd5, 2'b01}) begin
         errors++;
         $display("FAIL div_zero: valid=%b q=%h r=%h tag=%0d st=%b, required 1 ff 00 5 01",
                  seen, out_quotient, out_remainder, out_tag, out_status);
      end
      wait_drain(10);
   endtask

   task automatic test_fill;
      logic [21:0] held;
      out_ready = 0; div_done = 1;
      for (int t = 0; t < 5; t++) push(16'(100 + 37 * t), 8'(t + 3), 4'(t));
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
         errors++;
         $display("FAIL fill_full: in_ready=%b out_valid=%b, required 0 1", in_ready, out_valid);
      end
      held = {out_quotient, out_remainder, out_tag, out_status};
      tick(3);
      checks++;
      if ({out_quotient, out_remainder, out_tag, out_status} !== held || in_ready !== 1'b0 || out_tag !== 4'd0) begin
         errors++;
         $display("FAIL fill_stable: outputs=%h in_ready=%b tag=%0d, required %h 0 0",
                  {out_quotient, out_remainder, out_tag, out_status}, in_ready, out_tag, held);
      end
      out_ready = 1;
      push(16'd777, 8'd11, 4'd5);
      wait_drain(30);
   endtask

   task automatic test_done_stall;
      out_ready = 1; div_done = 0;
      push(16'd100, 8'd7, 4'd6);
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++;
         if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL done_stall: out_valid=%b cycle %0d, required 0", out_valid, i);
         end
      end
      div_done = 1;
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_tag !== 4'd6) begin
         errors++;
         $display("FAIL done_capture: out_valid=%b tag=%0d, required 1 6", out_valid, out_tag);
      end
      wait_drain(10);
   endtask

   task automatic test_back_to_back;
      out_ready = 1; div_done = 1;
      hs_times.delete();
      rec_en = 1;
      for (int t = 0; t < 12; t++)
         push(16'($urandom), (t == 5) ? 8'd0 : 8'($urandom_range(1, 255)), 4'(t));
      wait_drain(60);
      rec_en = 0;
      checks++;
      if (hs_times.size() != 12) begin
         errors++;
         $display("FAIL stream_count: %0d results, required 12", hs_times.size());
      end
      for (int i = 1; i < hs_times.size(); i++) begin
         checks++;
         if (hs_times[i] - hs_times[i-1] != 20) begin
            errors++;
            $display("FAIL stream_rate: gap %0t before result %0d, required 20", hs_times[i] - hs_times[i-1], i);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_div_zero();
      test_fill();
      test_done_stall();
      test_back_to_back();
      test_reset_mid_op();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end
endmodule

// File: doc/div_request_stage.md
Name: div_request_stage

Overview:
- Issue stage directly upstream of the combinational 16/8 divider.
- Buffers incoming divide requests in a small FIFO and presents the head entry's operands to the divider.
- After a programmable settle interval, captures the divider's quotient, remainder and status into a registered output with a valid/ready handshake.
- Traps divide-by-zero locally, so the divider's result for a zero divisor is never used.

Parameters:
- DEPTH, 4, request FIFO entries (power of two, ≥2).
- TAG_W, 4, width of the request tag carried alongside each request.
- SETTLE_CYCLES, 1, cycles the operands are held stable on div_* before sampling (≥1).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  request present.
- in_ready  out  1  FIFO can accept a request.
- in_dividend  in  16  request dividend.
- in_divisor  in  8  request divisor.
- in_tag  in  TAG_W  request tag.
- div_dividend  out  16  operand to divider (head entry).
- div_divisor  out  8  operand to divider (head entry).
- div_quotient  in  8  divider quotient.
- div_remainder  in  8  divider remainder.
- div_done  in  1  divider result valid.
- out_valid  out  1  result register full.
- out_ready  in  1  consumer accepts result.
- out_quotient  out  8  captured quotient.
- out_remainder  out  8  captured remainder.
- out_tag  out  TAG_W  tag of captured request.
- out_status  out  2  00 ok, 01 divide-by-zero, 10 divider not done (reserved), 11 unused.

Behaviour:
- Reset, async, takes effect immediately:
  - FIFO emptied, state IDLE, settle counter 0.
  - in_ready=1, out_valid=0, out_quotient=0, out_remainder=0, out_tag=0, out_status=00.
  - div_dividend=0, div_divisor=0.
- FIFO:
  - Push when in_valid && in_ready.
  - in_ready = (count != DEPTH), derived from registered count only.
  - Pop only in CAPTURE on a successful capture. Push and pop in the same cycle are legal; count stays unchanged.
  - Pointers wrap modulo DEPTH.
  - div_dividend and div_divisor are driven from the head entry whenever the FIFO is non-empty. Otherwise they hold the last driven values; after reset they are 0.
- FSM states IDLE, SETTLE, CAPTURE:
  - IDLE: if count != 0, load counter = SETTLE_CYCLES-1 and go to SETTLE.
  - SETTLE: if counter == 0, go to CAPTURE; otherwise decrement.
  - CAPTURE: a capture is allowed when !out_valid or (out_valid && out_ready).
    - If the head divisor == 0: capture out_quotient=8'hFF, out_remainder=8'h00, out_status=01. div_done is ignored.
    - Else if div_done==1: capture div_quotient, div_remainder, out_status=00.
    - Else: stay in CAPTURE, no capture.
    - On capture: out_tag=head tag, out_valid=1, pop FIFO.
    - Next state: SETTLE with counter reload if count-after-pop != 0, else IDLE.
- Latency:
  - Push at edge E gives the earliest out_valid at edge E+SETTLE_CYCLES+2 when empty and idle.
  - Sustained throughput is one result per SETTLE_CYCLES+1 cycles.
- Output register:
  - out_valid clears on out_valid && out_ready unless a new capture occurs in the same cycle, in which case it stays 1 with the new data.
  - Outputs are stable while out_valid && !out_ready.
- A push into an empty FIFO in the same cycle as a pop of the last entry is accepted normally. The FSM sees count != 0 next cycle.
- Backpressure (out_valid && !out_ready) holds the FSM in CAPTURE. The FIFO keeps accepting until full.

Test Plan:
- Reset mid-operation: 3 pushes, assert rst during SETTLE → out_valid=0, in_ready=1, FIFO empty. The next request's tag is returned first.
- Single request, stub divider returning q=8'h2A r=8'h05 done=1, dividend 16'h1234, divisor 8'h07, tag 3:
  - div_dividend=16'h1234 and div_divisor=8'h07 while the entry is at the head.
  - Result q=2A, r=05, tag=3, status=00 at edge E+3 (SETTLE_CYCLES=1).
- Divisor 0, tag 5 → q=FF, r=00, status=01, div_done held 0 throughout.
- Fill: out_ready=0, push 6 requests with tags 0–5:
  - in_ready drops after 4 pushes into the FIFO, plus 1 captured.
  - Release out_ready → tags emerge 0,1,2,3,4 in order, no loss or duplication.
- div_done held 0 for 5 cycles on a non-zero divisor → FSM stays in CAPTURE, out_valid stays 0. Raise done → capture on that edge.
- Streaming with out_ready=1 and continuous in_valid → one result per 2 cycles, with push and pop in the same cycle at count=DEPTH-1.
